// File: rtl/iir_ctrl.sv
// Coefficient/sample-flow controller for iir_filter: shadow coefficient set, drain-then-swap commit.
// Optional drain timeout is enabled by defining IIR_CTRL_TMO_EN.
module iir_ctrl #(
  parameter int unsigned NB    = 12,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned TMO   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_addr,
  input  logic [NB:0]           cfg_data,
  input  logic                  cfg_commit,
  output logic                  cfg_busy,
  input  logic                  vIn,
  input  logic [NB:0]           dIn,
  output logic                  rdy_o,
  output logic                  vOut_f,
  output logic [NB:0]           dOut_f,
  input  logic                  vRet,
  output logic [3*(NB+1)-1:0]   b_o,
  output logic [2*(NB+1)-1:0]   a_o,
  output logic                  err_o
);

  localparam int unsigned N_COEF = 5;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_APPLY} state_t;

  state_t             state_q, state_d;
  logic [NB:0]        shadow_q [0:N_COEF-1];
  logic [CNT_W-1:0]   cnt_q;
  logic               accept_c;
  logic               drain_done_c;
  logic               timeout_c;
  logic               inc_c, dec_c;

  if (TMO == 0) begin : g_tmo_chk
    $error("iir_ctrl: TMO must be nonzero");
  end

  assign accept_c     = vIn & rdy_o;
  assign drain_done_c = (cnt_q == '0) && !vOut_f;
  assign inc_c        = vOut_f;
  assign dec_c        = vRet && (cnt_q != '0);

`ifdef IIR_CTRL_TMO_EN
  localparam int unsigned TMO_W = (TMO > 1) ? $clog2(TMO) : 1;
  logic [TMO_W-1:0] tmo_q;

  // Counts cycles spent in DRAIN; restarts on every new drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q == S_DRAIN) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end else begin
      tmo_q <= '0;
    end
  end

  assign timeout_c = (state_q == S_DRAIN) && !drain_done_c && (tmo_q == TMO_W'(TMO - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (cfg_commit) state_d = S_DRAIN;
      S_DRAIN: if (drain_done_c || timeout_c) state_d = S_APPLY;
      S_APPLY: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // State register plus status outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      rdy_o    <= 1'b1;
      cfg_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_o    <= (state_d == S_RUN);
      cfg_busy <= (state_d != S_RUN);
    end
  end

  // Sample forwarding to the filter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vOut_f <= 1'b0;
      dOut_f <= '0;
    end else begin
      vOut_f <= accept_c;
      if (accept_c) dOut_f <= dIn;
    end
  end

  // In-flight counter: floors at zero, saturates at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (timeout_c) begin
      cnt_q <= '0;
    end else if (inc_c && !dec_c) begin
      if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end else if (dec_c && !inc_c) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Shadow writes are accepted in any state; a write in APPLY lands after the copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_COEF; i++) shadow_q[i] <= '0;
    end else if (cfg_we && (cfg_addr < 3'(N_COEF))) begin
      shadow_q[cfg_addr] <= cfg_data;
    end
  end

  // Active coefficient swap, all words in one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_o <= '0;
      a_o <= '0;
    end else if (state_q == S_APPLY) begin
      b_o <= {shadow_q[2], shadow_q[1], shadow_q[0]};
      a_o <= {shadow_q[4], shadow_q[3]};
    end
  end

  // Sticky drain-timeout flag; stays 0 when the timeout is not built in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (timeout_c) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iir_ctrl.sv
// Directed self-checking bench for iir_ctrl; covers the timeout path when IIR_CTRL_TMO_EN is defined.
module tb_iir_ctrl;
  localparam int unsigned NB    = 12;
  localparam int unsigned W     = NB + 1;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMO   = 16;

  logic             clk;
  logic             rst_n;
  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [NB:0]      cfg_data;
  logic             cfg_commit;
  logic             cfg_busy;
  logic             vIn;
  logic [NB:0]      dIn;
  logic             rdy_o;
  logic             vOut_f;
  logic [NB:0]      dOut_f;
  logic             vRet;
  logic [3*W-1:0]   b_o;
  logic [2*W-1:0]   a_o;
  logic             err_o;

  int n_chk;
  int n_fail;

  iir_ctrl #(.NB(NB), .CNT_W(CNT_W), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .vIn(vIn), .dIn(dIn), .rdy_o(rdy_o),
    .vOut_f(vOut_f), .dOut_f(dOut_f), .vRet(vRet),
    .b_o(b_o), .a_o(a_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [2:0] addr, input logic [NB:0] data);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    tick();
    cfg_we   = 1'b0;
  endtask

  function automatic logic [63:0] bvec(input logic [NB:0] b2, input logic [NB:0] b1, input logic [NB:0] b0);
    return 64'({b2, b1, b0});
  endfunction

  function automatic logic [63:0] avec(input logic [NB:0] a2, input logic [NB:0] a1);
    return 64'({a2, a1});
  endfunction

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    vIn = 1'b0; dIn = '0; vRet = 1'b0;

    // Reset values
    tick(2);
    check("rst_rdy",  64'(rdy_o), 64'd1);
    check("rst_busy", 64'(cfg_busy), 64'd0);
    check("rst_vout", 64'(vOut_f), 64'd0);
    check("rst_b",    64'(b_o), 64'd0);
    check("rst_a",    64'(a_o), 64'd0);
    check("rst_err",  64'(err_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic commit with nothing in flight; address 6 is reserved
    for (int i = 0; i < 5; i++) cfg_write(3'(i), W'(i + 1));
    cfg_write(3'd6, W'(12'hABC));
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("c1_busy_t1", 64'(cfg_busy), 64'd1);
    check("c1_rdy_t1",  64'(rdy_o), 64'd0);
    check("c1_b_t1",    64'(b_o), 64'd0);
    tick();
    check("c1_busy_t2", 64'(cfg_busy), 64'd1);
    check("c1_b_t2",    64'(b_o), 64'd0);
    tick();
    check("c1_busy_t3", 64'(cfg_busy), 64'd0);
    check("c1_rdy_t3",  64'(rdy_o), 64'd1);
    check("c1_b",       64'(b_o), bvec(W'(3), W'(2), W'(1)));
    check("c1_a",       64'(a_o), avec(W'(5), W'(4)));

    // Three samples, commit on the third, retire at +3..+5
    for (int i = 0; i < 5; i++) cfg_write(3'(i), W'(10 + i));
    vIn = 1'b1; dIn = W'(12'h010);
    tick();
    check("s0_vout", 64'(vOut_f), 64'd1);
    check("s0_dout", 64'(dOut_f), 64'h010);
    dIn = W'(12'h011);
    tick();
    dIn = W'(12'h012); cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0; dIn = W'(12'h0FF);
    cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = W'(12'h1F1);
    check("s2_vout",   64'(vOut_f), 64'd1);
    check("s2_dout",   64'(dOut_f), 64'h012);
    check("drain_rdy", 64'(rdy_o), 64'd0);
    tick();
    cfg_we = 1'b0;
    check("drain_block", 64'(vOut_f), 64'd0);
    check("drain_cnt3",  64'(dut.cnt_q), 64'd3);
    tick();
    vRet = 1'b1;
    tick(3);
    vRet = 1'b0;
    check("d_last_busy", 64'(cfg_busy), 64'd1);
    check("d_last_rdy",  64'(rdy_o), 64'd0);
    check("d_last_b",    64'(b_o), bvec(W'(3), W'(2), W'(1)));
    check("d_last_cnt",  64'(dut.cnt_q), 64'd0);
    tick();
    check("apply_busy", 64'(cfg_busy), 64'd1);
    check("apply_rdy",  64'(rdy_o), 64'd0);
    check("apply_b",    64'(b_o), bvec(W'(3), W'(2), W'(1)));
    check("apply_vout", 64'(vOut_f), 64'd0);
    tick();
    check("c2_rdy",  64'(rdy_o), 64'd1);
    check("c2_busy", 64'(cfg_busy), 64'd0);
    check("c2_b",    64'(b_o), bvec(W'(12), W'(11), W'(10)));
    check("c2_a",    64'(a_o), avec(W'(12'h1F1), W'(13)));
    tick();
    check("resume_vout", 64'(vOut_f), 64'd1);
    check("resume_dout", 64'(dOut_f), 64'h0FF);
    vIn = 1'b0;
    tick();
    check("cnt_one", 64'(dut.cnt_q), 64'd1);

    // Issue and retire in the same cycle, then a lone retire at zero
    vIn = 1'b1; dIn = W'(12'h020);
    tick();
    check("s3_vout", 64'(vOut_f), 64'd1);
    vIn = 1'b0; vRet = 1'b1;
    tick();
    check("cnt_same",  64'(dut.cnt_q), 64'd1);
    check("dout_hold", 64'(dOut_f), 64'h020);
    check("vout_idle", 64'(vOut_f), 64'd0);
    tick();
    check("cnt_zero", 64'(dut.cnt_q), 64'd0);
    tick();
    check("cnt_floor", 64'(dut.cnt_q), 64'd0);
    vRet = 1'b0;

    // Write on commit cycle is included, write in APPLY is deferred, busy commit is dropped
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = W'(12'h055); cfg_commit = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    cfg_commit = 1'b0; cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = W'(12'h066);
    tick();
    cfg_we = 1'b0;
    check("c3_b",    64'(b_o), bvec(W'(12), W'(11), W'(12'h055)));
    check("c3_busy", 64'(cfg_busy), 64'd0);
    tick();
    check("no_queue", 64'(cfg_busy), 64'd0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick(2);
    check("c4_b", 64'(b_o), bvec(W'(12), W'(12'h066), W'(12'h055)));

    // Two samples in flight with no retire
    vIn = 1'b1; dIn = W'(12'h030);
    tick();
    cfg_commit = 1'b1; dIn = W'(12'h031);
    tick();
    vIn = 1'b0; cfg_commit = 1'b0;
    tick(15);
    check("long_busy16", 64'(cfg_busy), 64'd1);
    check("long_err16",  64'(err_o), 64'd0);
`ifdef IIR_CTRL_TMO_EN
    tick();
    check("tmo_apply", 64'(cfg_busy), 64'd1);
    check("tmo_err",   64'(err_o), 64'd1);
    check("tmo_cnt",   64'(dut.cnt_q), 64'd0);
    tick();
    check("tmo_rdy",   64'(rdy_o), 64'd1);
    check("tmo_busy",  64'(cfg_busy), 64'd0);
    tick(3);
    check("tmo_sticky", 64'(err_o), 64'd1);
`else
    tick(4);
    check("long_busy20", 64'(cfg_busy), 64'd1);
    check("long_cnt20",  64'(dut.cnt_q), 64'd2);
    check("long_err20",  64'(err_o), 64'd0);
    vRet = 1'b1;
    tick(2);
    vRet = 1'b0;
    check("long_cnt0",  64'(dut.cnt_q), 64'd0);
    check("long_busy22", 64'(cfg_busy), 64'd1);
    tick();
    check("long_apply", 64'(cfg_busy), 64'd1);
    tick();
    check("long_done",  64'(cfg_busy), 64'd0);
    check("long_rdy",   64'(rdy_o), 64'd1);
`endif

    // Reset in DRAIN discards everything, shadow included
    for (int i = 0; i < 5; i++) cfg_write(3'(i), W'(12'h111 + i));
    vIn = 1'b1; dIn = W'(12'h040); cfg_commit = 1'b1;
    tick();
    vIn = 1'b0; cfg_commit = 1'b0;
    tick();
    check("pre_rst_busy", 64'(cfg_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy",  64'(rdy_o), 64'd1);
    check("mid_rst_busy", 64'(cfg_busy), 64'd0);
    check("mid_rst_b",    64'(b_o), 64'd0);
    check("mid_rst_a",    64'(a_o), 64'd0);
    check("mid_rst_err",  64'(err_o), 64'd0);
    check("mid_rst_cnt",  64'(dut.cnt_q), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick(2);
    check("post_rst_b",    64'(b_o), 64'd0);
    check("post_rst_a",    64'(a_o), 64'd0);
    check("post_rst_busy", 64'(cfg_busy), 64'd0);
    check("post_rst_rdy",  64'(rdy_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
